muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own HI/LO register pair, placed beside the main ALU in EX.
- Decodes R-type funct codes for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Runs shift-add multiply or restoring divide over WIDTH cycles.
- Raises a stall to the pipeline hazard logic while a result is pending.

Parameters:
WIDTH, 32, operand width; also the iteration count per operation.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage instruction is a valid mul/div/HI-LO R-type op this cycle
funct  input  6  instruction funct field
rs_data  input  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
rt_data  input  WIDTH  operand B (divisor / multiplier)
busy  output  1  operation in progress
stall  output  1  pipeline must hold EX and earlier stages this cycle
done  output  1  one-cycle pulse: HI/LO hold a new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
hilo_rdata  output  WIDTH  combinational: lo when funct=MFLO, else hi

Behaviour:
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Any other funct with start=1 is ignored, with no state change.
- Reset (synchronous, active-high; overrides everything, including mid-operation): state=IDLE; hi=lo=0; busy=0; done=0; stall=0; internal accumulators and iteration counter cleared. An in-flight operation is discarded.
- States:
  - IDLE: start with MULT/MULTU/DIV/DIVU latches operands, signedness and op type, then goes to RUN. Counter loads WIDTH.
  - RUN: one iteration per cycle; counter decrements. After the WIDTH-th iteration, goes to FIX.
  - FIX: applies sign correction, writes hi/lo at the end of the cycle, then goes to IDLE.
- Latency: start accepted in cycle T.
  - busy=1 in cycles T+1 through T+WIDTH+1.
  - New hi/lo are visible and done=1 in cycle T+WIDTH+2, with busy=0.
  - Total latency is WIDTH+2 (34 by default).
- busy = (state != IDLE).
- stall = start AND busy AND funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}.
  - A stalled start is ignored; the pipeline re-presents it each cycle until accepted.
  - In the cycle done=1, busy=0, so a waiting MFLO/MFHI is serviced that cycle from the new hi/lo.
- MTHI/MTLO in IDLE: hi (resp. lo) ← rs_data at the clock edge. Single cycle, no busy, no done.
- MFHI/MFLO in IDLE: hilo_rdata valid combinationally, no state change.
- Multiply:
  - Unsigned: 2*WIDTH-bit product → {hi,lo}.
  - MULT: multiply the magnitudes; in FIX, negate the 2*WIDTH-bit product if the operand signs differ.
- Divide:
  - Operates on magnitudes (restoring, one quotient bit per cycle).
  - lo = quotient; hi = remainder.
  - DIV: quotient negated if operand signs differ; remainder takes the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): full latency still taken; lo=all ones, hi=rs_data as latched. No exception.
- Operands are captured at acceptance; later changes on rs_data/rt_data have no effect on a running operation.
- hi/lo are never modified in RUN; they change only in FIX, on MTHI/MTLO, or on reset.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF at cycle T → busy T+1..T+33; at T+34 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/2 → lo=3, hi=1.
- DIVU rs=5 rt=0 → lo=0xFFFFFFFF, hi=5 after 34 cycles. DIV rs=0x80000000 rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 3*4 accepted at T, MFLO held with start=1 from T+1 → stall=1 for T+1..T+33, stall=0 at T+34 with hilo_rdata=0x0000000C. Second MULT presented during busy is stalled and not accepted early.
- MTHI rs=0x12345678 in IDLE → hi=0x12345678 next cycle, lo unchanged, busy never asserted, done=0.
- DIVU started at T, reset asserted at T+10 → cycle T+11: busy=0, hi=lo=0, done=0. MULTU 2*3 at T+11 → lo=6, hi=0 at T+45.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative multiply/divide unit with a private HI/LO register pair. It sits
// beside the main ALU in EX and services the R-type ops MULT/MULTU/DIV/DIVU
// (iterative, WIDTH+2 cycles) and MFHI/MFLO/MTHI/MTLO (single cycle).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (aborts any running op)
//   start      EX instruction is a valid mul/div/HI-LO op this cycle
//   funct      R-type funct field
//   rs_data    operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_data    operand B (divisor / multiplier)
//   busy       an iterative op is in progress
//   stall      hold EX and earlier: a HI/LO op arrived while busy
//   done       one-cycle pulse, HI/LO hold a new result
//   hi, lo     HI and LO registers
//   hilo_rdata lo when funct is MFLO, hi otherwise
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier bits being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] operand_b;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] dividend_raw;   // rs as accepted, returned in hi on /0
    logic             is_div, neg_result, neg_rem, div_zero;

    logic is_arith, is_hilo_op, accept;
    logic signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v,
                                                  input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    always_comb begin
        is_arith   = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
        is_hilo_op = is_arith || (funct inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO});
        // MULT (0x18) and DIV (0x1A) are the signed forms: funct[0] clear
        signed_op  = !funct[0];
        a_neg      = signed_op && rs_data[WIDTH-1];
        b_neg      = signed_op && rt_data[WIDTH-1];
        mag_a      = negate_w(rs_data, a_neg);
        mag_b      = negate_w(rt_data, b_neg);
    end

    assign busy       = (state != S_IDLE);
    assign stall      = start && busy && is_hilo_op;
    assign accept     = start && !busy && is_arith;
    assign hilo_rdata = (funct == F_MFLO) ? lo : hi;

    // One iteration step for each algorithm
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_b};
    end

    // Sign correction applied in FIX
    always_comb begin
        product_fixed = negate_2w({acc_hi, acc_lo}, neg_result);
        quo_fixed     = div_zero ? '1 : negate_w(acc_lo, neg_result);
        rem_fixed     = div_zero ? dividend_raw : negate_w(acc_hi, neg_rem);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (count == CNT_W'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            operand_b    <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_result   <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count        <= CNT_W'(WIDTH);
                        is_div       <= funct[1];
                        neg_result   <= a_neg ^ b_neg;
                        neg_rem      <= a_neg;
                        div_zero     <= funct[1] && (rt_data == '0);
                        dividend_raw <= rs_data;
                        acc_hi       <= '0;
                        if (funct[1]) begin
                            acc_lo    <= mag_a;
                            operand_b <= mag_b;
                        end else begin
                            acc_lo    <= mag_b;
                            operand_b <= mag_a;
                        end
                    end else if (start && funct == F_MTHI) begin
                        hi <= rs_data;
                    end else if (start && funct == F_MTLO) begin
                        lo <= rs_data;
                    end
                end
                S_RUN: begin
                    count <= count - CNT_W'(1);
                    if (is_div) begin
                        // Restoring step: keep the subtraction only if no borrow
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add step: add multiplicand on a set multiplier
                        // bit, then shift the whole {carry,hi,lo} right by one
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        hi <= product_fixed[2*WIDTH-1:WIDTH];
                        lo <= product_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [5:0]   funct;
    logic [W-1:0] rs_data, rt_data;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo, hilo_rdata;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo), .hilo_rdata(hilo_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an op, straight from arithmetic definitions
    function automatic logic [63:0] op_result(input logic [5:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULTU: return {32'h0, a} * {32'h0, b};
            F_MULT:  return 64'(sa * sb);
            F_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: remaining busy cycles, architectural hi/lo, pending result
    int           m_rem = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [63:0]  m_res = '0;
    logic         m_done = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (funct)
                    F_MTHI: m_hi = rs_data;
                    F_MTLO: m_lo = rs_data;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        m_res = op_result(funct, rs_data, rt_data);
                        m_rem = W + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_rem > 0);
            check("done", done, m_done);
            check("stall", stall, start && (m_rem > 0) &&
                  (funct inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU}));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("hilo_rdata", hilo_rdata, (funct == F_MFLO) ? m_lo : m_hi);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start an iterative op in the current cycle T and follow it to T+34
    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; funct = f; rs_data = a; rt_data = b;
        tick();
        start = 1'b0; funct = 6'h00;
        check({name, " busy@T+1"}, busy, 1'b1);
        repeat (W) tick();
        check({name, " busy@T+33"}, busy, 1'b1);
        check({name, " done@T+33"}, done, 1'b0);
        tick();
        check({name, " busy@T+34"}, busy, 1'b0);
        check({name, " done@T+34"}, done, 1'b1);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'h00; rs_data = '0; rt_data = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);

        run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3*5", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("divu 5/0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div -7/0", F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div 100/-7", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        // MFLO waiting on a running MULTU
        start = 1'b1; funct = F_MULTU; rs_data = 32'd3; rt_data = 32'd4;
        tick();
        funct = F_MFLO; rs_data = 32'hDEAD_BEEF; rt_data = 32'hDEAD_BEEF;
        check("mflo stall@T+1", stall, 1'b1);
        repeat (W) tick();
        check("mflo stall@T+33", stall, 1'b1);
        tick();
        check("mflo stall@T+34", stall, 1'b0);
        check("mflo rdata@T+34", hilo_rdata, 32'h0000_000C);
        start = 1'b0; funct = 6'h00;

        // Second MULT held during busy must not be accepted early
        start = 1'b1; funct = F_MULT; rs_data = 32'd2; rt_data = 32'd2;
        tick();
        rs_data = 32'd7; rt_data = 32'd7;
        check("mult2 stall@T+1", stall, 1'b1);
        repeat (W) tick();
        check("mult2 stall@T+33", stall, 1'b1);
        check("mult2 lo held", lo, 32'h0000_000C);
        tick();
        check("mult2 stall@T+34", stall, 1'b0);
        check("mult2 first lo", lo, 32'd4);
        tick();
        start = 1'b0; funct = 6'h00;
        check("mult2 busy after accept", busy, 1'b1);
        repeat (W + 1) tick();
        check("mult2 done", done, 1'b1);
        check("mult2 lo", lo, 32'd49);
        check("mult2 hi", hi, 32'd0);

        // MTHI in idle
        start = 1'b1; funct = F_MTHI; rs_data = 32'h1234_5678;
        tick();
        start = 1'b0; funct = 6'h00;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo", lo, 32'd49);
        check("mthi busy", busy, 1'b0);
        check("mthi done", done, 1'b0);

        // MTLO in idle
        start = 1'b1; funct = F_MTLO; rs_data = 32'hCAFE_0001;
        tick();
        start = 1'b0; funct = 6'h00;
        check("mtlo lo", lo, 32'hCAFE_0001);
        check("mtlo hi", hi, 32'h1234_5678);

        // Unknown funct is ignored
        start = 1'b1; funct = 6'h20; rs_data = 32'hAAAA_AAAA; rt_data = 32'h5;
        tick();
        start = 1'b0; funct = 6'h00;
        check("bad funct busy", busy, 1'b0);
        check("bad funct hi", hi, 32'h1234_5678);
        check("bad funct lo", lo, 32'hCAFE_0001);

        // Reset in the middle of a DIVU
        start = 1'b1; funct = F_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        start = 1'b0; funct = 6'h00;
        repeat (9) tick();
        check("abort busy@T+10", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy@T+11", busy, 1'b0);
        check("abort done@T+11", done, 1'b0);
        check("abort hi@T+11", hi, 32'h0);
        check("abort lo@T+11", lo, 32'h0);
        start = 1'b1; funct = F_MULTU; rs_data = 32'd2; rt_data = 32'd3;
        tick();
        start = 1'b0; funct = 6'h00;
        repeat (W) tick();
        check("post-abort done@T+44", done, 1'b0);
        tick();
        check("post-abort done@T+45", done, 1'b1);
        check("post-abort lo", lo, 32'd6);
        check("post-abort hi", hi, 32'd0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
